// File: rtl/mio_bus_responder.sv
`timescale 1ns/1ps
// mio_bus_responder
// Target side of the CPU_MIO / MemRead / MemWrite request and MIO_ready
// acknowledge handshake. Serves a word-addressed RAM, an LED output register
// and a switch input port, with WAIT_CYCLES wait states per access.
// Optional build macro: MIO_BUS_ERR_EN adds the bus_err output and returns
// 32'hDEAD_BEEF for unmapped reads.
//
// state   | meaning
// ST_IDLE | no access in flight; bus sampled for a new request
// ST_WAIT | wait states counting down on the captured request
// ST_DONE | access committed on entry; second cycle strobes MIO_ready

module mio_bus_responder #(
  parameter int          DEPTH       = 256,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] LED_ADDR    = 32'hE000_0000,
  parameter logic [31:0] SW_ADDR     = 32'hF000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CPU_MIO,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr_bus,
  input  logic [31:0] Data_out,
  output logic [31:0] Data_in,
  output logic        MIO_ready,
  input  logic [15:0] sw,
  output logic [15:0] led_out
`ifdef MIO_BUS_ERR_EN
  ,
  output logic        bus_err
`endif
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [3:0]  WAIT_LD   = 4'(WAIT_CYCLES);
  localparam logic [29:0] RAM_WORDS = 30'(DEPTH);
  localparam logic [29:0] LED_WORD  = LED_ADDR[31:2];
  localparam logic [29:0] SW_WORD   = SW_ADDR[31:2];
`ifdef MIO_BUS_ERR_EN
  localparam logic [31:0] UNMAPPED_RD = 32'hDEAD_BEEF;
`else
  localparam logic [31:0] UNMAPPED_RD = 32'h0000_0000;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  wait_cnt;
  logic [29:0] addr_q;
  logic [31:0] wdata_q;
  logic        wr_q;

  logic        req;
  logic        enter_done;
  logic [29:0] acc_addr;
  logic [31:0] acc_wdata;
  logic        acc_wr;
  logic        hit_ram;
  logic        hit_led;
  logic        hit_sw;
  logic        unmapped;
  logic [AW-1:0] ram_idx;
  logic [31:0] rd_data;
  logic        unused_addr_lsb;

  logic [31:0] mem [DEPTH];

  // Byte-offset bits carry no meaning on a word bus.
  assign unused_addr_lsb = ^addr_bus[1:0];

  // Both qualifiers high counts as a request and resolves to a write below.
  assign req = CPU_MIO & (MemRead | MemWrite);

  // With zero wait states the access commits on the capture edge itself, so
  // the live bus is used in IDLE and the captured copy everywhere else.
  always_comb begin
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_wr    = wr_q;
    if (state == ST_IDLE) begin
      acc_addr  = addr_bus[31:2];
      acc_wdata = Data_out;
      acc_wr    = MemWrite;
    end
  end

  assign hit_ram  = (acc_addr < RAM_WORDS);
  assign hit_led  = !hit_ram && (acc_addr == LED_WORD);
  assign hit_sw   = !hit_ram && !hit_led && (acc_addr == SW_WORD);
  assign unmapped = !(hit_ram || hit_led || hit_sw);
  assign ram_idx  = acc_addr[AW-1:0];

  // Read data mux for the access being committed.
  always_comb begin
    rd_data = UNMAPPED_RD;
    if (hit_ram) begin
      rd_data = mem[ram_idx];
    end else if (hit_led) begin
      rd_data = {16'h0000, led_out};
    end else if (hit_sw) begin
      rd_data = {16'h0000, sw};
    end
  end

  // Next-state logic; DONE is left only after MIO_ready has been strobed.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (req) begin
          state_nxt = (WAIT_LD == 4'd0) ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wait_cnt <= 4'd1) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (MIO_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign enter_done = (state != ST_DONE) && (state_nxt == ST_DONE);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request capture and wait-state down-counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= 4'd0;
      addr_q   <= 30'd0;
      wdata_q  <= 32'd0;
      wr_q     <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (req) begin
        wait_cnt <= WAIT_LD;
        addr_q   <= addr_bus[31:2];
        wdata_q  <= Data_out;
        wr_q     <= MemWrite;
      end
    end else if (state == ST_WAIT) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Acknowledge strobe, read data and LED register; reads and LED writes
  // take effect on the edge entering DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      MIO_ready <= 1'b0;
      Data_in   <= 32'd0;
      led_out   <= 16'h0000;
    end else begin
      MIO_ready <= (state == ST_DONE) && !MIO_ready;
      if (enter_done) begin
        if (acc_wr) begin
          if (hit_led) begin
            led_out <= acc_wdata[15:0];
          end
        end else begin
          Data_in <= rd_data;
        end
      end
    end
  end

  // RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (enter_done && acc_wr && hit_ram) begin
      mem[ram_idx] <= acc_wdata;
    end
  end

`ifdef MIO_BUS_ERR_EN
  logic err_q;

  // Error status latched at commit, presented alongside MIO_ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (enter_done) begin
      err_q <= unmapped || (acc_wr && hit_sw);
    end
  end

  assign bus_err = err_q & MIO_ready;
`else
  logic unused_unmapped;
  assign unused_unmapped = unmapped;
`endif

endmodule
